serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have a parameter N, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have a parameter W, default 8, giving the bits processed per cycle; N SHALL be an integer multiple of W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have ports A and B, input, N bits each: minuend and subtrahend.
REQ-008 The block SHALL have port Bin, input, 1 bit: borrow-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-011 The block SHALL have port Diff, output, N bits: A - B - Bin, modulo 2^N.
REQ-012 The block SHALL have port Bout, output, 1 bit: borrow-out, set when A < B + Bin.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-014 The FSM SHALL have three states, IDLE, CALC and DONE, with the transitions given in REQ-016 to REQ-019.
REQ-015 The block SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-016 In IDLE, an input accept (in_valid & in_ready) SHALL capture A, B and Bin into internal registers, clear the chunk counter and go to CALC.
REQ-017 In CALC, the block SHALL process one W-bit chunk per cycle, LSB chunk first, with the chunk borrow chained through a borrow register (initialised from Bin); each cycle it SHALL write the chunk result into the Diff register and increment the counter.
REQ-018 After chunk N/W-1, the FSM SHALL go to DONE and latch the final borrow into Bout; out_valid SHALL therefore rise exactly N/W cycles after the accept edge (4 at the defaults).
REQ-019 In DONE, Diff and Bout SHALL hold stable while out_ready = 0; on out_valid & out_ready the FSM SHALL go to IDLE, so in_ready is high on the following cycle.
REQ-020 The block SHALL ignore in_valid while busy; operands SHALL NOT be re-sampled during CALC.
REQ-021 Result values SHALL be bit-exact to (A - B - Bin) mod 2^N, including the wrap-around cases A=0,B=0,Bin=1 and A=0,B=2^N-1.

Reset
REQ-022 When rst = 1 at a clock edge, the FSM SHALL go to IDLE and the block SHALL clear Diff, Bout, out_valid, busy, the counter and the borrow register; in_ready SHALL be 1 on the first cycle after reset.
REQ-023 Reset SHALL take priority over any handshake; an operation in CALC or DONE SHALL be discarded with no out_valid pulse.

Configuration
REQ-024 With SERIAL_SUBTRACTOR_SATURATE_EN defined, the block SHALL force Diff to 0 in DONE whenever Bout = 1, and Bout SHALL still report the borrow.
REQ-025 Without SERIAL_SUBTRACTOR_SATURATE_EN, Diff SHALL be the modulo-2^N result.

Structure
REQ-026 A shared package SHALL hold the N and W defaults, the FSM state typedef (IDLE/CALC/DONE) and the chunk-count width constant $clog2(N/W).
REQ-027 The chunk arithmetic SHALL be one combinational sub-module, sub_chunk (W-bit x, y, b_in -> d, b_out), instantiated once.

Verification
REQ-028 Basic: A=32'h5, B=32'h3, Bin=0, out_ready=1 -> out_valid high 4 cycles after accept, Diff=32'h2, Bout=0.
REQ-029 Wrap: A=0, B=1, Bin=0 -> Diff=32'hFFFF_FFFF, Bout=1; with SERIAL_SUBTRACTOR_SATURATE_EN defined -> Diff=0, Bout=1.
REQ-030 Cross-chunk borrow: A=32'h0100_0000, B=1, Bin=0 -> Diff=32'h00FF_FFFF, Bout=0; Bin path: A=32'h10, B=32'hF, Bin=1 -> Diff=0, Bout=0.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE -> Diff, Bout and out_valid stay stable and in_ready stays 0, and a new in_valid pulse during this time is ignored.
REQ-032 Reset mid-op: assert rst during the 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, Diff=0, and no result is ever emitted for that operation.
REQ-033 Random: 1000 random A, B and Bin with random out_ready stalls -> every result matches the reference model and no result is lost or duplicated.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: default widths, FSM state type,
// chunk-counter width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_subtractor_pkg;

  localparam int N_DEF = 32;  // operand/result width
  localparam int W_DEF = 8;   // bits processed per cycle

  // Chunk-counter width at the default configuration.
  localparam int CNT_W_DEF = $clog2(N_DEF / W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary N/W.
  // Kept at least 1 bit so the single-chunk case (N == W) still has a legal vector.
  function automatic int cnt_width(input int n, input int w);
    return ((n / w) > 1) ? $clog2(n / w) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Signals: in_valid, in_ready, A, B, Bin (operands); out_valid, out_ready, Diff, Bout (result); busy.
// Modports: master = requester side; slave = the subtractor.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Diff;
  logic         Bout;
  logic         busy;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout, busy
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout, busy
  );

endinterface

// File: rtl/serial_subtractor_sub_chunk.sv
// One W-bit slice of a subtraction: d = x - y - b_in, with b_out = borrow.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y (W-bit operands), b_in (borrow in) -> d (W-bit difference), b_out (borrow out).
module sub_chunk
  import serial_subtractor_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         b_in,
  output logic [W-1:0] d,
  output logic         b_out
);

  // One extra bit on the left catches the borrow: it goes to 1 exactly
  // when x < y + b_in, since the result then wraps negative.
  logic [W:0] w_full;

  assign w_full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, b_in};
  assign d      = w_full[W-1:0];
  assign b_out  = w_full[W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin (mod 2^N), Bout = borrow, W bits per cycle, LSB chunk first.
// Latency: out_valid rises N/W cycles after the accept edge; in_ready returns the cycle after the result handshake.
// Backpressure: one operation in flight; in_ready only in IDLE, result held stable in DONE until out_ready.
// Ports: clk, rst (synchronous, active-high); bus (serial_subtractor_if.slave) carries operands, result, busy.
// Build option: SERIAL_SUBTRACTOR_SATURATE_EN forces Diff to 0 in DONE when the result borrowed.
// N must be an integer multiple of W.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int NCH   = N / W;
  localparam int CNT_W = cnt_width(N, W);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CNT_W-1:0] r_cnt;

  int               w_base;
  logic [W-1:0]     w_x;
  logic [W-1:0]     w_y;
  logic [W-1:0]     w_d;
  logic             w_bout;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_last = (r_cnt == LAST_CHUNK);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  // Operands are captured once at accept and never re-sampled, so in_valid
  // activity while busy cannot disturb an operation in progress.
  assign w_base = int'(r_cnt) * W;
  assign w_x    = r_a[w_base +: W];
  assign w_y    = r_b[w_base +: W];

  sub_chunk #(.W(W)) u_sub_chunk (
    .x     (w_x),
    .y     (w_y),
    .b_in  (r_borrow),
    .d     (w_d),
    .b_out (w_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_a      <= bus.A;
        r_b      <= bus.B;
        r_borrow <= bus.Bin;
        r_cnt    <= '0;
      end else if (r_state == CALC) begin
        r_diff[w_base +: W] <= w_d;
        r_borrow            <= w_bout;
        r_cnt               <= r_cnt + 1'b1;
        if (w_last) begin
          r_bout <= w_bout;
        end
      end
    end
  end

  // ---------------- Outputs ----------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.Bout      = r_bout;

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
  // Clamp a negative result to zero while presenting it; Bout still reports the borrow.
  assign bus.Diff = ((r_state == DONE) && r_bout) ? '0 : r_diff;
`else
  assign bus.Diff = r_diff;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor (N=32, W=8).
// Latency: expects out_valid 4 cycles after the accept edge.
// Backpressure: exercises out_ready stalls and ignored in_valid while busy.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  localparam int N   = 32;
  localparam int W   = 8;
  localparam int NCH = N / W;

  logic clk;
  logic rst;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_res    = 0;
  int exp_res  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) n_acc <= n_acc + 1;
      if (bus.out_valid && bus.out_ready) n_res <= n_res + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the saturation option to a hand-computed modulo result.
  function automatic logic [N-1:0] sat(input logic [N-1:0] d, input logic b);
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    return b ? '0 : d;
`else
    return d;
`endif
  endfunction

  // Reference model: returns {borrow, diff}.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    logic [N:0] r;
    r = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    return {r[N], sat(r[N-1:0], r[N])};
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic bin, input logic [N-1:0] ed, input logic eb, input int stall);
    int lat;
    bus.A         = a;
    bus.B         = b;
    bus.Bin       = bin;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    chk($sformatf("%s.in_ready", tag), 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("%s.latency", tag), 64'(lat), 64'(NCH));
    repeat (stall) tick();
    chk($sformatf("%s.out_valid", tag), 64'(bus.out_valid), 64'd1);
    chk($sformatf("%s.diff", tag), 64'(bus.Diff), 64'(ed));
    chk($sformatf("%s.bout", tag), 64'(bus.Bout), 64'(eb));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_res++;
    chk($sformatf("%s.ready_after", tag), 64'(bus.in_ready), 64'd1);
    chk($sformatf("%s.valid_after", tag), 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb, ed;
    logic         rbin;
    logic [N:0]   m;
    logic         seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.diff", 64'(bus.Diff), 64'd0);
    chk("rst.bout", 64'(bus.Bout), 64'd0);

    // Directed vectors
    run_op("basic", 32'h5, 32'h3, 1'b0, 32'h2, 1'b0, 0);
    run_op("wrap_b1", 32'h0, 32'h1, 1'b0, sat(32'hFFFF_FFFF, 1'b1), 1'b1, 0);
    run_op("wrap_bin", 32'h0, 32'h0, 1'b1, sat(32'hFFFF_FFFF, 1'b1), 1'b1, 1);
    run_op("wrap_max", 32'h0, 32'hFFFF_FFFF, 1'b0, sat(32'h1, 1'b1), 1'b1, 0);
    run_op("cross", 32'h0100_0000, 32'h1, 1'b0, 32'h00FF_FFFF, 1'b0, 2);
    run_op("bin_path", 32'h10, 32'hF, 1'b1, 32'h0, 1'b0, 0);
    run_op("top_max", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("equal", 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 32'h0, 1'b0, 0);

    // Backpressure with an ignored in_valid pulse while in DONE
    bus.A        = 32'h1234_5678;
    bus.B        = 32'h0234_5679;
    bus.Bin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (NCH) tick();
    chk("bp.out_valid0", 64'(bus.out_valid), 64'd1);
    bus.A        = 32'hDEAD_BEEF;
    bus.B        = 32'h1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp.out_valid%0d", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp.in_ready%0d", k), 64'(bus.in_ready), 64'd0);
      chk($sformatf("bp.diff%0d", k), 64'(bus.Diff), 64'h0FFF_FFFF);
      chk($sformatf("bp.bout%0d", k), 64'(bus.Bout), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_res++;
    chk("bp.in_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp.no_new_op", 64'(bus.busy), 64'd0);

    // Reset during the 2nd CALC cycle
    bus.A        = 32'h5;
    bus.B        = 32'h3;
    bus.Bin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("mid.busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid.diff", 64'(bus.Diff), 64'd0);
    chk("mid.busy", 64'(bus.busy), 64'd0);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    chk("mid.no_result", 64'(seen), 64'd0);

    // Random operands with random result stalls
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom();
      rb   = $urandom();
      rbin = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = '0;
        1: rb = '1;
        2: rb = ra;
        default: ;
      endcase
      m  = model(ra, rb, rbin);
      ed = m[N-1:0];
      run_op($sformatf("rnd%0d", i), ra, rb, rbin, ed, m[N], int'($urandom_range(0, 3)));
    end

    tick();
    chk("count.results", 64'(n_res), 64'(exp_res));
    chk("count.accepts", 64'(n_acc), 64'(exp_res + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
